// File: rtl/alarm_pkg.sv
// Shared types and default cadence constants for the alarm tone generator.
//   alarm_tone_state_t : cadence FSM state encoding
//   DEF_*              : default parameter values (100 MHz clock, 880 Hz tone)
//   max3()             : helper that sizes the shared segment counter
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEEP  = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } alarm_tone_state_t;

  localparam int DEF_TONE_HALF_PERIOD = 56818;
  localparam int DEF_BEEP_LEN         = 10_000_000;
  localparam int DEF_GAP_LEN          = 10_000_000;
  localparam int DEF_BEEPS_PER_BURST  = 4;
  localparam int DEF_PAUSE_LEN        = 50_000_000;
  localparam int DEF_TIMEOUT_BURSTS   = 60;
  localparam int DEF_VOL_W            = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_pwm_mod.sv
// Volume PWM stage: a free-running counter compared against the volume.
//   pclk_i    : clock
//   presetn_i : asynchronous active-low reset
//   clear_i   : restart the PWM counter at 0 on the next cycle
//   gate_i    : enables the output (tone high and beeping)
//   volume_i  : duty; 0 = always off
//   aud_pwm   : registered PWM output
module alarm_pwm_mod #(
  parameter int VOL_W = 8
) (
  input  logic             pclk_i,
  input  logic             presetn_i,
  input  logic             clear_i,
  input  logic             gate_i,
  input  logic [VOL_W-1:0] volume_i,
  output logic             aud_pwm
);

  logic [VOL_W-1:0] pwm_cnt;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      pwm_cnt <= '0;
      aud_pwm <= 1'b0;
    end else begin
      pwm_cnt <= clear_i ? '0 : pwm_cnt + 1'b1;
      aud_pwm <= gate_i & (pwm_cnt < volume_i);
    end
  end

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: turns an alarm-match pulse into a beep cadence
// (BEEPS_PER_BURST beeps with gaps, then a pause) driving a PWM audio pin.
//   pclk_i       : clock
//   presetn_i    : asynchronous active-low reset
//   alarm_trig_i : 1-cycle pulse, start ringing (ignored while ringing)
//   alarm_off_i  : 1-cycle pulse, stop ringing (highest priority)
//   volume_i     : PWM duty, 0 = silent
//   ringing_o    : high while the cadence FSM is not IDLE
//   timeout_o    : 1-cycle pulse when ringing ends by burst timeout
//   aud_pwm      : PWM audio output
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_HALF_PERIOD = DEF_TONE_HALF_PERIOD,
  parameter int BEEP_LEN         = DEF_BEEP_LEN,
  parameter int GAP_LEN          = DEF_GAP_LEN,
  parameter int BEEPS_PER_BURST  = DEF_BEEPS_PER_BURST,
  parameter int PAUSE_LEN        = DEF_PAUSE_LEN,
  parameter int TIMEOUT_BURSTS   = DEF_TIMEOUT_BURSTS,
  parameter int VOL_W            = DEF_VOL_W
) (
  input  logic             pclk_i,
  input  logic             presetn_i,
  input  logic             alarm_trig_i,
  input  logic             alarm_off_i,
  input  logic [VOL_W-1:0] volume_i,
  output logic             ringing_o,
  output logic             timeout_o,
  output logic             aud_pwm
);

  localparam int SEG_W   = $clog2(max3(BEEP_LEN, GAP_LEN, PAUSE_LEN) + 1);
  localparam int HALF_W  = $clog2(TONE_HALF_PERIOD + 1);
  localparam int BEEP_W  = $clog2(BEEPS_PER_BURST + 1);
  localparam int BURST_W = (TIMEOUT_BURSTS > 0) ? $clog2(TIMEOUT_BURSTS + 1) : 1;

  localparam logic [SEG_W-1:0]   BEEP_LAST  = SEG_W'(BEEP_LEN - 1);
  localparam logic [SEG_W-1:0]   GAP_LAST   = SEG_W'(GAP_LEN - 1);
  localparam logic [SEG_W-1:0]   PAUSE_LAST = SEG_W'(PAUSE_LEN - 1);
  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(TONE_HALF_PERIOD - 1);
  localparam logic [BEEP_W-1:0]  BEEP_IDX_LAST = BEEP_W'(BEEPS_PER_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_IDX_LAST =
    (TIMEOUT_BURSTS > 0) ? BURST_W'(TIMEOUT_BURSTS - 1) : '0;

  alarm_tone_state_t   state;
  logic [SEG_W-1:0]    seg_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic [BEEP_W-1:0]   beep_idx;
  logic [BURST_W-1:0]  burst_idx;
  logic                tone_ph;

  logic                pwm_clear;
  logic                pwm_gate;

  // alarm_off_i also closes the gate so aud_pwm drops in the same cycle
  // that ringing_o does, despite the PWM output register.
  assign pwm_clear = (state == IDLE) & alarm_trig_i & ~alarm_off_i;
  assign pwm_gate  = (state == BEEP) & tone_ph & ~alarm_off_i;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state     <= IDLE;
      seg_cnt   <= '0;
      half_cnt  <= '0;
      beep_idx  <= '0;
      burst_idx <= '0;
      tone_ph   <= 1'b0;
      ringing_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (alarm_off_i) begin
        state     <= IDLE;
        seg_cnt   <= '0;
        ringing_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (alarm_trig_i) begin
              state     <= BEEP;
              ringing_o <= 1'b1;
              seg_cnt   <= '0;
              half_cnt  <= '0;
              beep_idx  <= '0;
              burst_idx <= '0;
              tone_ph   <= 1'b1;
            end
          end
          BEEP: begin
            if (half_cnt == HALF_LAST) begin
              half_cnt <= '0;
              tone_ph  <= ~tone_ph;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
            if (seg_cnt == BEEP_LAST) begin
              seg_cnt <= '0;
              state   <= (beep_idx < BEEP_IDX_LAST) ? GAP : PAUSE;
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
          GAP: begin
            if (seg_cnt == GAP_LAST) begin
              seg_cnt  <= '0;
              state    <= BEEP;
              beep_idx <= beep_idx + 1'b1;
              tone_ph  <= 1'b1;
              half_cnt <= '0;
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
          PAUSE: begin
            if (seg_cnt == PAUSE_LAST) begin
              seg_cnt   <= '0;
              burst_idx <= burst_idx + 1'b1;
              if ((TIMEOUT_BURSTS != 0) && (burst_idx == BURST_IDX_LAST)) begin
                state     <= IDLE;
                ringing_o <= 1'b0;
                timeout_o <= 1'b1;
              end else begin
                // Every burst restarts its first beep in the same tone phase.
                state    <= BEEP;
                beep_idx <= '0;
                tone_ph  <= 1'b1;
                half_cnt <= '0;
              end
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  alarm_pwm_mod #(
    .VOL_W (VOL_W)
  ) u_pwm (
    .pclk_i    (pclk_i),
    .presetn_i (presetn_i),
    .clear_i   (pwm_clear),
    .gate_i    (pwm_gate),
    .volume_i  (volume_i),
    .aud_pwm   (aud_pwm)
  );

endmodule
